// File: rtl/segment_issue_ctrl.sv
// rtl/segment_issue_ctrl.sv - credit-based issue controller for segment micro-ops
// Optional stall perf counter: define SEGMENT_ISSUE_PERF_CNT_EN.
module segment_issue_ctrl #(
  parameter int unsigned MaxInflight = 4,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned ReqWidth    = 64,
  localparam int unsigned InfWidth   = $clog2(MaxInflight + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                seq_start_i,
  input  logic [CntWidth-1:0] seq_total_i,
  input  logic                uop_valid_i,
  output logic                uop_ready_o,
  input  logic [ReqWidth-1:0] uop_req_i,
  output logic                be_valid_o,
  input  logic                be_ready_i,
  output logic [ReqWidth-1:0] be_req_o,
  input  logic                uop_done_i,
  input  logic                uop_exc_i,
  output logic [InfWidth-1:0] inflight_o,
  output logic                busy_o,
  output logic                seq_done_o,
  output logic                seq_exc_o,
  output logic [CntWidth-1:0] exc_idx_o,
  output logic [31:0]         stall_cycles_o
);

  typedef enum logic [1:0] {Idle, Issue, Drain, Done} state_e;

  localparam logic [InfWidth-1:0] MaxInf = InfWidth'(MaxInflight);

  state_e              state_q;
  logic [CntWidth-1:0] total_q, issued_q, completed_q, exc_idx_q;
  logic [InfWidth-1:0] inflight_q, inflight_nxt;
  logic                exc_q;
  logic                can_issue, fire, done_ok, exc_hit;

  assign can_issue = (state_q == Issue) && (inflight_q < MaxInf) && (issued_q < total_q);
  assign be_valid_o  = uop_valid_i & can_issue;
  assign uop_ready_o = be_ready_i & can_issue;
  assign be_req_o    = uop_req_i;
  assign fire        = be_valid_o & be_ready_i;
  // A completion with nothing in flight is a protocol error; the count holds at 0.
  assign done_ok     = uop_done_i & (inflight_q != '0);
  assign exc_hit     = uop_done_i & uop_exc_i & ~exc_q;

  always_comb begin
    inflight_nxt = inflight_q;
    if (fire && !done_ok) begin
      inflight_nxt = inflight_q + InfWidth'(1);
    end else if (!fire && done_ok) begin
      inflight_nxt = inflight_q - InfWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      total_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      exc_idx_q   <= '0;
      inflight_q  <= '0;
      exc_q       <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (seq_start_i) begin
            total_q     <= seq_total_i;
            issued_q    <= '0;
            completed_q <= '0;
            exc_idx_q   <= '0;
            inflight_q  <= '0;
            exc_q       <= 1'b0;
            state_q     <= (seq_total_i == '0) ? Done : Issue;
          end
        end
        Issue: begin
          if (fire) begin
            issued_q <= issued_q + CntWidth'(1);
          end
          if (exc_hit || (fire && (issued_q + CntWidth'(1) == total_q))) begin
            state_q <= Drain;
          end
        end
        Drain: begin
          if (inflight_nxt == '0) begin
            state_q <= Done;
          end
        end
        Done:    state_q <= Idle;
        default: state_q <= Idle;
      endcase
      if (state_q != Idle) begin
        inflight_q <= inflight_nxt;
        if (uop_done_i) begin
          completed_q <= completed_q + CntWidth'(1);
        end
        if (exc_hit) begin
          exc_q     <= 1'b1;
          exc_idx_q <= completed_q;
        end
      end
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = (state_q != Idle);
  assign seq_done_o = (state_q == Done);
  assign seq_exc_o  = (state_q == Done) & exc_q;
  assign exc_idx_o  = ((state_q == Done) && exc_q) ? exc_idx_q : '0;

  done_without_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (uop_done_i && state_q != Idle) |-> (inflight_q != '0));

`ifdef SEGMENT_ISSUE_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (state_q == Idle && seq_start_i) begin
      stall_q <= '0;
    end else if (state_q == Issue && uop_valid_i && !uop_ready_o && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_segment_issue_ctrl.sv
// tb/tb_segment_issue_ctrl.sv - scoreboard bench for segment_issue_ctrl
module tb_segment_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        seq_start_i;
  logic [15:0] seq_total_i;
  logic        uop_valid_i;
  logic        uop_ready_o;
  logic [63:0] uop_req_i;
  logic        be_valid_o;
  logic        be_ready_i;
  logic [63:0] be_req_o;
  logic        uop_done_i;
  logic        uop_exc_i;
  logic [2:0]  inflight_o;
  logic        busy_o;
  logic        seq_done_o;
  logic        seq_exc_o;
  logic [15:0] exc_idx_o;
  logic [31:0] stall_cycles_o;

  segment_issue_ctrl #(.MaxInflight(4), .CntWidth(16), .ReqWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .seq_start_i(seq_start_i), .seq_total_i(seq_total_i),
    .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o), .uop_req_i(uop_req_i),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready_i), .be_req_o(be_req_o),
    .uop_done_i(uop_done_i), .uop_exc_i(uop_exc_i), .inflight_o(inflight_o),
    .busy_o(busy_o), .seq_done_o(seq_done_o), .seq_exc_o(seq_exc_o),
    .exc_idx_o(exc_idx_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  int cyc = 0, fires = 0, dones = 0, done_pulses = 0, max_inf = 0;
  int lat = 3, done_gap = 1, done_budget = -1, exc_at = -1, exc_at2 = -1;
  int ncomp = 0, last_drv_cyc = -100, done_seen_cyc = 0, start_cyc = 0, exc_fires = -1;
  bit hold_done = 0;
  logic [63:0] exp_req_q[$];
  int          done_due[$];
  bit          exp_exc_q[$];
  int          exp_idx_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit fired;
    @(negedge clk_i);
    fired = be_valid_o && be_ready_i;
    if (inflight_o > max_inf) max_inf = inflight_o;
    if (inflight_o == 3'd4) check_eq("full_no_fire", be_valid_o, 0);
    if (fired) begin
      fires++;
      check_eq("be_req", be_req_o, exp_req_q.pop_front());
      done_due.push_back(cyc + lat);
    end
    if (uop_done_i) dones++;
    if (seq_done_o) begin
      done_pulses++;
      done_seen_cyc = cyc;
      if (exp_exc_q.size() > 0) begin
        check_eq("seq_exc", seq_exc_o, exp_exc_q.pop_front());
        check_eq("exc_idx", exc_idx_o, exp_idx_q.pop_front());
      end else begin
        check_eq("seq_done_spurious", seq_done_o, 0);
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    seq_start_i = 1'b0;
    if (fired) begin
      uop_req_i = {$urandom(), $urandom()};
      exp_req_q.push_back(uop_req_i);
    end
    uop_done_i = 1'b0;
    uop_exc_i  = 1'b0;
    if (!hold_done && done_budget != 0 && done_due.size() > 0 && done_due[0] <= cyc &&
        cyc - last_drv_cyc >= done_gap) begin
      void'(done_due.pop_front());
      uop_done_i = 1'b1;
      uop_exc_i  = (ncomp == exc_at) || (ncomp == exc_at2);
      if (ncomp == exc_at) exc_fires = fires;
      ncomp++;
      last_drv_cyc = cyc;
      if (done_budget > 0) done_budget--;
    end
  endtask

  task automatic start_seq(input int total, input bit exc, input int idx);
    seq_start_i = 1'b1;
    seq_total_i = 16'(total);
    exp_exc_q.push_back(exc);
    exp_idx_q.push_back(idx);
    ncomp = 0;
    exc_fires = -1;
    start_cyc = cyc;
    tick();
  endtask

  task automatic run_until_done(input string tag, input int bound);
    int p = done_pulses;
    int n = 0;
    while (done_pulses == p && n < bound) begin
      tick();
      n++;
    end
    check_eq(tag, done_pulses - p, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_be_valid"}, be_valid_o, 0);
    check_eq({tag, "_uop_ready"}, uop_ready_o, 0);
    check_eq({tag, "_inflight"}, inflight_o, 0);
    check_eq({tag, "_done"}, {seq_done_o, seq_exc_o, exc_idx_o}, 0);
    check_eq({tag, "_stall"}, stall_cycles_o, 0);
    check_eq({tag, "_be_req"}, be_req_o, exp_req_q[0]);
  endtask

  initial begin
    int f0, d0, s0;
    rst_ni = 1'b0; seq_start_i = 1'b0; seq_total_i = '0;
    uop_valid_i = 1'b1; be_ready_i = 1'b1; uop_done_i = 1'b0; uop_exc_i = 1'b0;
    uop_req_i = 64'h0123_4567_89ab_cdef;
    exp_req_q.push_back(uop_req_i);
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // Nominal: 6 micro-ops, completion 3 cycles after issue
    f0 = fires; d0 = dones; lat = 3;
    start_seq(6, 0, 0);
    run_until_done("nominal_timeout", 60);
    check_eq("nominal_fires", fires - f0, 6);
    check_eq("nominal_dones", dones - d0, 6);
    check_eq("nominal_done_after_last_completion", done_seen_cyc - last_drv_cyc, 1);

    // Credit stall: no completions until four are outstanding
    f0 = fires; lat = 1; hold_done = 1;
    start_seq(8, 0, 0);
    repeat (5) tick();
    s0 = stall_cycles_o;
    repeat (4) tick();
    #1;
    check_eq("stall_fires", fires - f0, 4);
    check_eq("stall_inflight", inflight_o, 4);
    check_eq("stall_ready", uop_ready_o, 0);
`ifdef SEGMENT_ISSUE_PERF_CNT_EN
    check_eq("stall_count", stall_cycles_o - s0, 4);
`else
    check_eq("stall_count_off", stall_cycles_o | 32'(s0), 0);
`endif
    hold_done = 0; done_budget = 1;
    repeat (5) tick();
    check_eq("stall_one_credit", fires - f0, 5);
    done_budget = -1;
    run_until_done("stall_timeout", 60);
    check_eq("stall_total_fires", fires - f0, 8);

    // Exception on the 3rd completion with 4 in flight; 5th completion also faults
    f0 = fires; d0 = dones; hold_done = 1; lat = 1;
    start_seq(10, 1, 2);
    repeat (6) tick();
    hold_done = 0; done_gap = 2; exc_at = 2; exc_at2 = 4;
    run_until_done("exc_timeout", 60);
    check_eq("exc_no_more_fires", fires, exc_fires);
    check_eq("exc_fires", fires - f0, 6);
    check_eq("exc_drained", dones - d0, 6);
    done_gap = 1; exc_at = -1; exc_at2 = -1;

    // Steady state fire + done at two in flight; stray start while busy
    f0 = fires; d0 = done_pulses; lat = 2;
    start_seq(20, 0, 0);
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check_eq("steady_inflight", inflight_o, 2);
    end
    seq_start_i = 1'b1; seq_total_i = 16'd3;
    tick();
    run_until_done("steady_timeout", 60);
    repeat (3) tick();
    check_eq("steady_fires", fires - f0, 20);
    check_eq("busy_start_ignored", done_pulses - d0, 1);

    // Zero-length sequence, started back to back
    f0 = fires;
    start_seq(0, 0, 0);
    run_until_done("zero_timeout", 5);
    check_eq("zero_latency", done_seen_cyc - start_cyc, 1);
    check_eq("zero_fires", fires - f0, 0);

    // Reset mid-ISSUE
    lat = 3;
    start_seq(10, 0, 0);
    repeat (3) tick();
    rst_ni = 1'b0;
    tick();
    uop_done_i = 1'b0; uop_exc_i = 1'b0;
    done_due.delete(); exp_exc_q.delete(); exp_idx_q.delete();
    check_reset_outputs("midreset");
    rst_ni = 1'b1;
    tick();

    f0 = fires;
    start_seq(3, 0, 0);
    run_until_done("post_reset_timeout", 40);
    check_eq("post_reset_fires", fires - f0, 3);
    check_eq("max_inflight_le_4", max_inf <= 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
